// File: rtl/register_bank.sv
// rtl/register_bank.sv - parameterised register bank with RW, read-only and write-1-to-clear registers
module register_bank #(
  parameter int                     WIDTH          = 32,
  parameter int                     DEPTH          = 4,
  parameter int                     ADDR_WIDTH     = 8,
  parameter logic [DEPTH-1:0]       RO_MASK        = '0,
  parameter logic [DEPTH-1:0]       W1C_MASK       = '0,
  parameter logic [DEPTH*WIDTH-1:0] RESET_VALUE    = '0,
  parameter logic [31:0]            BAD_ADDR_VALUE = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_w_en,
  input  logic [ADDR_WIDTH-1:0]    i_w_addr,
  input  logic [WIDTH-1:0]         i_w_value,
  input  logic                     i_r_en,
  input  logic [ADDR_WIDTH-1:0]    i_r_addr,
  output logic [WIDTH-1:0]         o_r_value,
  output logic                     o_r_valid,
  output logic                     o_r_err,
  output logic                     o_w_err,
  input  logic [DEPTH*WIDTH-1:0]   i_hw_value,
  input  logic [DEPTH*WIDTH-1:0]   i_hw_set,
  output logic [DEPTH*WIDTH-1:0]   o_regs,
  output logic [DEPTH-1:0]         o_w_strobe
);

  localparam logic [WIDTH-1:0] BAD_VALUE = WIDTH'(BAD_ADDR_VALUE);

  logic [DEPTH-1:0][WIDTH-1:0] regs_q;
  logic [DEPTH-1:0][WIDTH-1:0] regs_d;
  logic [DEPTH-1:0]            w_hit;
  logic [DEPTH-1:0]            r_hit;
  logic [DEPTH-1:0]            w_accept;
  logic [WIDTH-1:0]            r_data;
  logic [WIDTH-1:0]            clr;
  logic                        unused_inputs;

  // Slices of per-register inputs that a given mask leaves idle stay referenced here.
  assign unused_inputs = ^{i_hw_value, i_hw_set};

  // Out-of-range addresses simply match no register, so no range compare is needed.
  always_comb begin
    w_hit = '0;
    r_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hit[i] = i_w_en && (i_w_addr == ADDR_WIDTH'(i));
      r_hit[i] = (i_r_addr == ADDR_WIDTH'(i));
    end
  end

  assign w_accept = w_hit & ~RO_MASK;

  always_comb begin
    r_data = BAD_VALUE;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_hit[i]) r_data = regs_q[i];
    end
  end

  always_comb begin
    regs_d = regs_q;
    clr    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      clr = w_hit[i] ? i_w_value : '0;
      if (RO_MASK[i]) begin
        regs_d[i] = i_hw_value[i*WIDTH +: WIDTH];
      end else if (W1C_MASK[i]) begin
        // Set is applied after clear so a simultaneous set wins.
        regs_d[i] = (regs_q[i] & ~clr) | i_hw_set[i*WIDTH +: WIDTH];
      end else if (w_hit[i]) begin
        regs_d[i] = i_w_value;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= RO_MASK[i] ? '0 : RESET_VALUE[i*WIDTH +: WIDTH];
      end
      o_r_value  <= '0;
      o_r_valid  <= 1'b0;
      o_r_err    <= 1'b0;
      o_w_err    <= 1'b0;
      o_w_strobe <= '0;
    end else begin
      regs_q     <= regs_d;
      o_r_valid  <= i_r_en;
      o_r_err    <= i_r_en && !(|r_hit);
      if (i_r_en) o_r_value <= r_data;
      o_w_err    <= i_w_en && !(|w_accept);
      o_w_strobe <= w_accept;
    end
  end

  assign o_regs = regs_q;

endmodule
